axi4_lite_slave_read_q: RTL and testbench

- AXI4-Lite read-channel slave, next generation of our single-transaction read slave.
- Buffers up to AR_DEPTH read addresses in an internal FIFO, decodes each against a configurable address window and alignment rule, and issues one backing-memory access at a time.
- Returns R beats in AR order with OKAY/SLVERR/DECERR responses.
- Sits between the AXI4-Lite interconnect and the on-chip memory / register-file read port.

---
 rtl/axi4_lite_pkg.sv | 20 ++
 rtl/axi4_lite_sync_fifo.sv | 56 +++++
 rtl/axi4_lite_slave_read_q.sv | 190 +++++++++++++++++++
 tb/tb_axi4_lite_slave_read_q.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite slave family (read and write channels).
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } t_resp;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    MEM,
    RESP
  } t_rd_state;

  localparam int PROT_W = 3;

endpackage

// File: rtl/axi4_lite_sync_fifo.sv
// Generic synchronous FIFO with show-ahead read data; full/empty/count derived from a registered count.
module axi4_lite_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // Power-of-two depth lets the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;

endmodule

// File: rtl/axi4_lite_slave_read_q.sv
// AXI4-Lite read slave: queued AR addresses, window/alignment decode, one memory access at a time.
// state  | meaning
// IDLE   | waiting for a queued address; pops the FIFO head
// DECODE | range/alignment check of the popped address
// MEM    | memory request outstanding, waiting for i_mem_ack
// RESP   | R beat presented, waiting for R_READY
module axi4_lite_slave_read_q
  import axi4_lite_pkg::*;
#(
  parameter int          AXI_ADDR_WIDTH = 64,
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          AR_DEPTH       = 4,
  parameter logic [63:0] ADDR_BASE      = 64'h0,
  parameter logic [63:0] ADDR_SIZE      = 64'h1000
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic                          AR_VALID,
  input  logic [AXI_ADDR_WIDTH-1:0]     AR_ADDR,
  input  logic [2:0]                    AR_PROT,
  output logic                          AR_READY,
  input  logic                          R_READY,
  output logic                          R_VALID,
  output logic [AXI_DATA_WIDTH-1:0]     R_DATA,
  output logic [1:0]                    R_RESP,
  output logic                          o_mem_req,
  output logic [AXI_ADDR_WIDTH-1:0]     o_mem_addr,
  output logic [2:0]                    o_mem_prot,
  input  logic                          i_mem_ack,
  input  logic [AXI_DATA_WIDTH-1:0]     i_mem_data,
  input  logic                          i_mem_err,
  output logic [$clog2(AR_DEPTH):0]     o_ar_count
);

  localparam int CW      = $clog2(AR_DEPTH) + 1;
  localparam int AW      = AXI_ADDR_WIDTH;
  localparam int ALIGN_W = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [AW-1:0] WIN_LO   = AW'(ADDR_BASE);
  localparam logic [AW:0]   WIN_SIZE = (AW + 1)'(ADDR_SIZE);

  // Entry width follows AXI_ADDR_WIDTH, so the layout is declared per instance.
  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [PROT_W-1:0] prot;
  } t_ar_entry;

  t_rd_state                state_q, state_d;
  t_ar_entry                push_entry, head_entry;
  logic                     fifo_full, fifo_empty;
  logic [CW-1:0]            fifo_count, count_next;
  logic                     ar_ready_q, ar_push, fifo_pop;
  logic [AW-1:0]            addr_q;
  logic [PROT_W-1:0]        prot_q;
  logic [AW:0]              offset_ext;
  logic                     in_window, misaligned;
  logic                     err_load, mem_start, mem_done, beat_done;
  t_resp                    err_code;
  logic                     r_valid_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
  t_resp                    r_resp_q;
  logic                     mem_req_q;
  logic [AW-1:0]            mem_addr_q;
  logic [PROT_W-1:0]        mem_prot_q;

  assign push_entry = '{addr: AR_ADDR, prot: AR_PROT};
  assign ar_push    = AR_VALID & ar_ready_q & ~fifo_full;

  axi4_lite_sync_fifo #(
    .WIDTH ($bits(t_ar_entry)),
    .DEPTH (AR_DEPTH)
  ) u_ar_fifo (
    .clk     (clk),
    .arstn   (arstn),
    .wr_en   (ar_push),
    .wr_data (push_entry),
    .rd_en   (fifo_pop),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // AR_READY reflects the occupancy after this edge, so a full FIFO never accepts.
  assign count_next = fifo_count + CW'(ar_push) - CW'(fifo_pop);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) ar_ready_q <= 1'b0;
    else        ar_ready_q <= (count_next != CW'(AR_DEPTH));
  end

  // Borrow bit of the subtraction flags addresses below the window.
  assign offset_ext = {1'b0, addr_q} - {1'b0, WIN_LO};
  assign in_window  = ~offset_ext[AW] && (offset_ext < WIN_SIZE);
  assign misaligned = |addr_q[ALIGN_W-1:0];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    err_load  = 1'b0;
    err_code  = OKAY;
    mem_start = 1'b0;
    mem_done  = 1'b0;
    beat_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (!in_window) begin
          err_load = 1'b1;
          err_code = DECERR;
          state_d  = RESP;
        end else if (misaligned) begin
          err_load = 1'b1;
          err_code = SLVERR;
          state_d  = RESP;
        end else begin
          mem_start = 1'b1;
          state_d   = MEM;
        end
      end
      MEM: begin
        if (i_mem_ack) begin
          mem_done = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (R_READY) begin
          beat_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      addr_q     <= '0;
      prot_q     <= '0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= OKAY;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_prot_q <= '0;
    end else begin
      if (fifo_pop) begin
        addr_q <= head_entry.addr;
        prot_q <= head_entry.prot;
      end
      if (err_load) begin
        r_valid_q <= 1'b1;
        r_data_q  <= '0;
        r_resp_q  <= err_code;
      end
      if (mem_start) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= offset_ext[AW-1:0];
        mem_prot_q <= prot_q;
      end
      if (mem_done) begin
        mem_req_q <= 1'b0;
        r_valid_q <= 1'b1;
        r_data_q  <= i_mem_data;
        r_resp_q  <= i_mem_err ? SLVERR : OKAY;
      end
      if (beat_done) r_valid_q <= 1'b0;
    end
  end

  assign AR_READY   = ar_ready_q;
  assign R_VALID    = r_valid_q;
  assign R_DATA     = r_data_q;
  assign R_RESP     = r_resp_q;
  assign o_mem_req  = mem_req_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_prot = mem_prot_q;
  assign o_ar_count = fifo_count;

endmodule

// File: tb/tb_axi4_lite_slave_read_q.sv
// Scoreboard bench: expected beats and memory accesses queued at AR acceptance, checked by monitors.
module tb_axi4_lite_slave_read_q;

  localparam int          AW    = 64;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [63:0] BASE  = 64'h2000;
  localparam logic [63:0] SIZE  = 64'h1000;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          AR_VALID = 1'b0;
  logic [AW-1:0] AR_ADDR = '0;
  logic [2:0]    AR_PROT = '0;
  logic          AR_READY;
  logic          R_READY = 1'b1;
  logic          R_VALID;
  logic [DW-1:0] R_DATA;
  logic [1:0]    R_RESP;
  logic          o_mem_req;
  logic [AW-1:0] o_mem_addr;
  logic [2:0]    o_mem_prot;
  logic          i_mem_ack = 1'b0;
  logic [DW-1:0] i_mem_data = '0;
  logic          i_mem_err = 1'b0;
  logic [2:0]    o_ar_count;

  axi4_lite_slave_read_q #(
    .AXI_ADDR_WIDTH (AW), .AXI_DATA_WIDTH (DW), .AR_DEPTH (DEPTH),
    .ADDR_BASE (BASE), .ADDR_SIZE (SIZE)
  ) dut (
    .clk (clk), .arstn (arstn),
    .AR_VALID (AR_VALID), .AR_ADDR (AR_ADDR), .AR_PROT (AR_PROT), .AR_READY (AR_READY),
    .R_READY (R_READY), .R_VALID (R_VALID), .R_DATA (R_DATA), .R_RESP (R_RESP),
    .o_mem_req (o_mem_req), .o_mem_addr (o_mem_addr), .o_mem_prot (o_mem_prot),
    .i_mem_ack (i_mem_ack), .i_mem_data (i_mem_data), .i_mem_err (i_mem_err),
    .o_ar_count (o_ar_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [1:0] resp; } exp_r_t;
  typedef struct { logic [63:0] off; logic [2:0] prot; } exp_m_t;

  exp_r_t      exp_r[$];
  exp_m_t      exp_m[$];
  logic [31:0] mem_data [1024];
  bit          mem_err  [1024];
  int          checks = 0;
  int          errors = 0;
  int          mem_wait = 0;
  bit          ack_noise = 1'b0;
  int          rr_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: window, then alignment, then the memory tables.
  task automatic model_push(input logic [63:0] addr, input logic [2:0] prot);
    exp_r_t r;
    exp_m_t m;
    logic [63:0] off;
    if (addr < BASE || addr >= BASE + SIZE) begin
      r.data = 32'h0; r.resp = 2'b11;
    end else if (addr % 4 != 0) begin
      r.data = 32'h0; r.resp = 2'b10;
    end else begin
      off = addr - BASE;
      r.data = mem_data[int'(off >> 2)];
      r.resp = mem_err[int'(off >> 2)] ? 2'b10 : 2'b00;
      m.off = off; m.prot = prot;
      exp_m.push_back(m);
    end
    exp_r.push_back(r);
  endtask

  // Called #1 after a rising edge; returns #1 after the handshake edge.
  task automatic send_ar(input logic [63:0] addr, input logic [2:0] prot);
    bit rdy;
    bit done = 1'b0;
    AR_VALID = 1'b1; AR_ADDR = addr; AR_PROT = prot;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk); rdy = AR_READY;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
    end
    AR_VALID = 1'b0;
    if (done) model_push(addr, prot);
    else chk("ar_handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic latency(output int req_k, output int rv_k);
    req_k = 0; rv_k = 0;
    for (int k = 1; k <= 30 && rv_k == 0; k++) begin
      @(posedge clk); #1;
      if (o_mem_req && req_k == 0) req_k = k;
      if (R_VALID) rv_k = k;
    end
  endtask

  task automatic wait_rvalid();
    for (int k = 0; k < 40 && !R_VALID; k++) begin
      @(posedge clk); #1;
    end
    chk("rvalid_timeout", R_VALID, 1'b1);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_r.size() != 0 && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_pending", exp_r.size(), 0);
    @(posedge clk); #1;
  endtask

  always begin
    @(posedge clk); #1;
    case (rr_mode)
      0: R_READY = 1'b1;
      1: R_READY = ($urandom % 4) != 0;
      2: R_READY = 1'b0;
      default: ;
    endcase
  end

  // Memory responder: ack after mem_wait cycles of request, random noise otherwise.
  always begin
    int cnt;
    @(posedge clk); #1;
    if (!arstn) begin
      i_mem_ack = 1'b0; cnt = 0;
    end else if (i_mem_ack) begin
      i_mem_ack = 1'b0; cnt = 0;
    end else if (o_mem_req) begin
      if (cnt >= mem_wait) begin
        i_mem_ack  = 1'b1;
        i_mem_data = mem_data[o_mem_addr[11:2]];
        i_mem_err  = mem_err[o_mem_addr[11:2]];
      end else cnt++;
    end else if (ack_noise && ($urandom % 4) == 0) begin
      i_mem_ack = 1'b1;
    end
    if (!i_mem_ack || !o_mem_req) begin
      i_mem_data = $urandom;
      i_mem_err  = 1'($urandom % 2);
    end
  end

  // Memory-side monitor: every new request must match the next queued access and stay stable.
  always begin
    bit prev_req = 1'b0;
    logic [63:0] h_addr;
    logic [2:0]  h_prot;
    exp_m_t m;
    forever begin
      @(negedge clk);
      if (!arstn) prev_req = 1'b0;
      else begin
        if (o_mem_req && !prev_req) begin
          if (exp_m.size() == 0) chk("mem_unexpected_req", o_mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            m = exp_m.pop_front();
            chk("mem_addr", o_mem_addr, m.off);
            chk("mem_prot", o_mem_prot, m.prot);
          end
          h_addr = o_mem_addr; h_prot = o_mem_prot;
        end else if (o_mem_req) begin
          chk("mem_addr_stable", o_mem_addr, h_addr);
          chk("mem_prot_stable", o_mem_prot, h_prot);
        end
        prev_req = o_mem_req;
      end
    end
  end

  // R monitor: pops on each handshake; checks hold-stability while stalled.
  always begin
    bit stall = 1'b0;
    logic [31:0] s_data;
    logic [1:0]  s_resp;
    exp_r_t r;
    forever begin
      @(negedge clk);
      if (!arstn) stall = 1'b0;
      else begin
        if (stall) begin
          chk("r_valid_hold", R_VALID, 1'b1);
          chk("r_data_hold", R_DATA, s_data);
          chk("r_resp_hold", R_RESP, s_resp);
        end
        if (R_VALID && R_READY) begin
          if (exp_r.size() == 0) chk("r_unexpected_beat", R_RESP, 64'hFF);
          else begin
            r = exp_r.pop_front();
            chk("r_data", R_DATA, r.data);
            chk("r_resp", R_RESP, r.resp);
          end
        end
        stall = R_VALID && !R_READY;
        s_data = R_DATA; s_resp = R_RESP;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_k, rv_k;
    logic [31:0] d;
    logic [1:0]  rs;
    logic [63:0] a;
    for (int i = 0; i < 1024; i++) begin
      mem_data[i] = $urandom;
      mem_err[i]  = ($urandom % 8) == 0;
    end
    mem_data[4] = 32'hDEADBEEF; mem_err[4] = 1'b0;
    mem_err[16] = 1'b1;
    for (int i = 8; i < 12; i++) mem_err[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ar_ready", AR_READY, 0);
    chk("rst_r_valid", R_VALID, 0);
    chk("rst_r_data", R_DATA, 0);
    chk("rst_r_resp", R_RESP, 0);
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_prot", o_mem_prot, 0);
    chk("rst_ar_count", o_ar_count, 0);
    arstn = 1'b1;
    @(posedge clk); #1;
    chk("ar_ready_after_rst", AR_READY, 1);

    // Single OK read, zero-wait memory.
    send_ar(BASE + 64'h10, 3'b010);
    latency(req_k, rv_k);
    chk("lat_mem_req", req_k, 2);
    chk("lat_r_valid", rv_k, 3);
    drain(50);

    // Decode error at the top boundary, then misaligned.
    send_ar(BASE + SIZE, 3'b001);
    latency(req_k, rv_k);
    chk("decerr_no_req", req_k, 0);
    chk("decerr_lat", rv_k, 2);
    chk("decerr_resp", R_RESP, 2'b11);
    drain(50);
    send_ar(BASE + 64'h2, 3'b000);
    latency(req_k, rv_k);
    chk("slverr_no_req", req_k, 0);
    chk("slverr_lat", rv_k, 2);
    chk("slverr_resp", R_RESP, 2'b10);
    drain(50);

    // Fill the FIFO while a beat is stalled.
    mem_wait = 3;
    rr_mode = 2; R_READY = 1'b0;
    send_ar(BASE + 64'h100, 3'b011);
    wait_rvalid();
    for (int i = 0; i < 4; i++) send_ar(BASE + 64'(i * 4), 3'(i));
    chk("fill_ar_ready", AR_READY, 0);
    chk("fill_count", o_ar_count, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("fill_ar_ready_hold", AR_READY, 0);
    chk("fill_count_hold", o_ar_count, 4);
    rr_mode = 0; R_READY = 1'b1;
    drain(200);

    // Memory error with a five-cycle R stall.
    mem_wait = 0;
    rr_mode = 3; R_READY = 1'b0;
    send_ar(BASE + 64'h40, 3'b101);
    wait_rvalid();
    d = R_DATA; rs = R_RESP;
    chk("memerr_resp", rs, 2'b10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", R_VALID, 1);
      chk("stall_data", R_DATA, d);
      chk("stall_resp", R_RESP, rs);
    end
    R_READY = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", R_VALID, 0);
    rr_mode = 0;
    drain(20);

    // Reset while in MEM with two entries queued.
    mem_wait = 50;
    for (int i = 0; i < 3; i++) send_ar(BASE + 64'h20 + 64'(i * 4), 3'b110);
    for (int k = 0; k < 20 && !(o_mem_req && o_ar_count == 2); k++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_mem_req", o_mem_req, 1);
    chk("pre_rst_count", o_ar_count, 2);
    @(posedge clk); #2;
    arstn = 1'b0;
    #1;
    chk("mid_rst_ar_ready", AR_READY, 0);
    chk("mid_rst_r_valid", R_VALID, 0);
    chk("mid_rst_r_data", R_DATA, 0);
    chk("mid_rst_r_resp", R_RESP, 0);
    chk("mid_rst_mem_req", o_mem_req, 0);
    chk("mid_rst_mem_addr", o_mem_addr, 0);
    chk("mid_rst_mem_prot", o_mem_prot, 0);
    chk("mid_rst_count", o_ar_count, 0);
    exp_r.delete(); exp_m.delete();
    mem_wait = 0;
    repeat (2) @(posedge clk);
    #1;
    arstn = 1'b1;
    @(posedge clk); #1;
    send_ar(BASE + 64'h10, 3'b111);
    drain(50);
    repeat (10) @(posedge clk);
    #1;

    // Randomized traffic with random R back-pressure and spurious acks.
    rr_mode = 1; ack_noise = 1'b1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom % 8)
        5:       a = BASE + 64'(($urandom % 1024) * 4 + 1 + $urandom % 3);
        6:       a = BASE - 64'd1 - 64'($urandom % 64);
        7:       a = BASE + SIZE + 64'($urandom % 64);
        default: a = BASE + 64'(($urandom % 1024) * 4);
      endcase
      mem_wait = $urandom % 4;
      send_ar(a, 3'($urandom));
      if (($urandom % 3) == 0) repeat ($urandom % 4) begin
        @(posedge clk); #1;
      end
    end
    drain(2000);
    chk("mem_queue_empty", exp_m.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
